// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver. The serial line is synchronised, each bit is sampled at its
// middle, and complete bytes go into a small first-word-fall-through FIFO with a valid/ready output.
module uart_rx_fifo #(
  parameter int BAUD_DIV    = 434,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              rx_i,
  output logic [7:0]                        rx_data_o,
  output logic                              rx_valid_o,
  input  logic                              rx_ready_i,
  output logic                              frame_err_o,
  output logic                              overrun_o,
  output logic                              busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(BAUD_DIV);
  localparam logic [DW-1:0] CNT_HALF = DW'(BAUD_DIV / 2 - 1);
  localparam logic [DW-1:0] CNT_LAST = DW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  state_e            state_q, state_d;
  logic [DW-1:0]     cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              push, ferr;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              frame_err_q, overrun_q;
  logic              pop, full, wr_en, ovr;

  // Idle-high line: the synchroniser resets to 1 so reset never looks like a start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    push    = 1'b0;
    ferr    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rxs ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr    = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      ST_BREAK: begin
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot the incoming byte needs, even when full.
  assign pop   = rx_valid_o && rx_ready_i;
  assign full  = (count_q == CNT_FULL);
  assign wr_en = push && (!full || pop);
  assign ovr   = push && full && !pop;

  always_comb begin
    count_d = count_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q     <= count_d;
      frame_err_q <= ferr;
      overrun_q   <= ovr;
    end
  end

  assign rx_data_o    = mem_q[rd_ptr_q];
  assign rx_valid_o   = (count_q != '0);
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at 8 clocks per bit: expected bytes are queued as
// frames are driven and compared against bytes popped off the valid/ready stream.
module tb_uart_rx_fifo;

  localparam int BD = 8;

  logic       clk;
  logic       rst;
  logic       rx_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;
  logic [2:0] fifo_count_o;

  int vectors;
  int miscompares;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int fe_cnt;
  int ov_cnt;
  int vld_cnt;

  uart_rx_fifo #(.BAUD_DIV(BD), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_i         (rx_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .busy_o       (busy_o),
    .fifo_count_o (fifo_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records what the DUT produces; comparisons happen in the scenario tasks.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid_o && rx_ready_i) got_q.push_back(rx_data_o);
      if (frame_err_o) fe_cnt++;
      if (overrun_o) ov_cnt++;
      if (rx_valid_o) vld_cnt++;
    end
  end

  // Drives one 10-bit frame, BD clocks per bit; ready_pulse raises ready only on the push cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit ready_pulse);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int k = 0; k < 10 * BD; k++) begin
      @(negedge clk);
      rx_i = frame[k / BD];
      if (ready_pulse) rx_ready_i = (k == 10 * BD - 2);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx_i = 1'b1;
    rx_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({rx_data_o, rx_valid_o, frame_err_o, overrun_o, busy_o, fifo_count_o} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got data=%h valid=%b fe=%b ov=%b busy=%b cnt=%0d, want all 0",
               rx_data_o, rx_valid_o, frame_err_o, overrun_o, busy_o, fifo_count_o);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if ({rx_valid_o, busy_o, fifo_count_o} !== 5'd0) begin
      miscompares++;
      $display("FAIL after_reset: got valid=%b busy=%b cnt=%0d, want 0", rx_valid_o, busy_o, fifo_count_o);
    end
  endtask

  task automatic test_single;
    int fe0, ov0, v0;
    logic [7:0] g, e;
    fe0 = fe_cnt; ov0 = ov_cnt; v0 = vld_cnt;
    rx_ready_i = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL single_count: got %0d bytes, want %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      vectors++;
      if (g !== e) begin miscompares++; $display("FAIL single_data: got %h want %h", g, e); end
    end
    vectors++;
    if (vld_cnt - v0 != 1) begin
      miscompares++;
      $display("FAIL single_valid_cycles: got %0d want 1", vld_cnt - v0);
    end
    vectors++;
    if (fe_cnt != fe0 || ov_cnt != ov0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_flags: got fe=%0d ov=%0d busy=%b want 0 0 0", fe_cnt - fe0, ov_cnt - ov0, busy_o);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3];
    logic [7:0] g, e;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
    rx_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(bytes[i]);
      send_frame(bytes[i], 1'b1, 1'b0);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (fifo_count_o !== 3'd3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d want 3", fifo_count_o);
    end
    rx_ready_i = 1'b1;
    repeat (6) @(negedge clk);
    rx_ready_i = 1'b0;
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b_pops: got %0d bytes, want %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      vectors++;
      if (g !== e) begin miscompares++; $display("FAIL b2b_data: got %h want %h", g, e); end
    end
    vectors++;
    if (fifo_count_o !== 3'd0) begin
      miscompares++;
      $display("FAIL b2b_empty: got count %0d want 0", fifo_count_o);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_overrun;
    int ov0;
    logic [7:0] g, e;
    ov0 = ov_cnt;
    rx_ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 1'b0);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (fifo_count_o !== 3'd4) begin
      miscompares++;
      $display("FAIL ovr_count: got %0d want 4", fifo_count_o);
    end
    vectors++;
    if (ov_cnt - ov0 != 1) begin
      miscompares++;
      $display("FAIL ovr_pulse: got %0d pulses want 1", ov_cnt - ov0);
    end
    rx_ready_i = 1'b1;
    repeat (8) @(negedge clk);
    rx_ready_i = 1'b0;
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL ovr_pops: got %0d bytes, want %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      vectors++;
      if (g !== e) begin miscompares++; $display("FAIL ovr_data: got %h want %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_frame_error;
    int fe0, ov0;
    logic [7:0] g, e;
    fe0 = fe_cnt; ov0 = ov_cnt;
    rx_ready_i = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    rx_i = 1'b1;
    repeat (6) @(negedge clk);
    vectors++;
    if (fe_cnt - fe0 != 1 || ov_cnt != ov0) begin
      miscompares++;
      $display("FAIL ferr_pulse: got fe=%0d ov=%0d want 1 0", fe_cnt - fe0, ov_cnt - ov0);
    end
    vectors++;
    if (fifo_count_o !== 3'd0 || got_q.size() != 0) begin
      miscompares++;
      $display("FAIL ferr_discard: got count=%0d pops=%0d want 0 0", fifo_count_o, got_q.size());
    end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL ferr_recover_count: got %0d bytes, want %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      vectors++;
      if (g !== e) begin miscompares++; $display("FAIL ferr_recover_data: got %h want %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch;
    int fe0, ov0;
    logic seen_busy;
    fe0 = fe_cnt; ov0 = ov_cnt;
    seen_busy = 1'b0;
    rx_ready_i = 1'b1;
    @(negedge clk); rx_i = 1'b0;
    @(negedge clk);
    @(negedge clk); rx_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy_o) seen_busy = 1'b1;
    end
    vectors++;
    if (seen_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_start: got busy seen=%b want 1", seen_busy);
    end
    vectors++;
    if (busy_o !== 1'b0 || got_q.size() != 0 || fe_cnt != fe0 || ov_cnt != ov0) begin
      miscompares++;
      $display("FAIL glitch_idle: got busy=%b pops=%0d fe=%0d ov=%0d want 0 0 0 0",
               busy_o, got_q.size(), fe_cnt - fe0, ov_cnt - ov0);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid;
    logic [9:0] frame;
    logic [7:0] g, e;
    frame = {1'b1, 8'hC3, 1'b0};
    rx_ready_i = 1'b0;
    for (int k = 0; k < 4 * BD; k++) begin
      @(negedge clk);
      rx_i = frame[k / BD];
    end
    vectors++;
    if (busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_busy: got %b want 1", busy_o);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({rx_data_o, rx_valid_o, frame_err_o, overrun_o, busy_o, fifo_count_o} !== 15'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got data=%h valid=%b fe=%b ov=%b busy=%b cnt=%0d, want all 0",
               rx_data_o, rx_valid_o, frame_err_o, overrun_o, busy_o, fifo_count_o);
    end
    rx_i = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    rx_ready_i = 1'b1;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL midreset_recover_count: got %0d bytes, want %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      vectors++;
      if (g !== e) begin miscompares++; $display("FAIL midreset_data: got %h want %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_full_push_pop;
    int ov0;
    logic [7:0] g, e;
    rx_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (fifo_count_o !== 3'd4) begin
      miscompares++;
      $display("FAIL fullpp_prefill: got count %0d want 4", fifo_count_o);
    end
    ov0 = ov_cnt;
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1, 1'b1);
    rx_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (fifo_count_o !== 3'd4 || ov_cnt != ov0) begin
      miscompares++;
      $display("FAIL fullpp_count: got count=%0d ov=%0d want 4 0", fifo_count_o, ov_cnt - ov0);
    end
    vectors++;
    if (got_q.size() != 1) begin
      miscompares++;
      $display("FAIL fullpp_single_pop: got %0d pops want 1", got_q.size());
    end
    rx_ready_i = 1'b1;
    repeat (8) @(negedge clk);
    rx_ready_i = 1'b0;
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL fullpp_pops: got %0d bytes, want %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      vectors++;
      if (g !== e) begin miscompares++; $display("FAIL fullpp_data: got %h want %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    fe_cnt = 0;
    ov_cnt = 0;
    vld_cnt = 0;
    rst = 1'b1;
    rx_i = 1'b1;
    rx_ready_i = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_error();
    test_glitch();
    test_reset_mid();
    test_full_push_pop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
